multi_axis_step_gen: RTL and testbench
======================================

// Module: multi_axis_step_gen
// PURPOSE
//  - Parametrised N-axis stepper pulse generator for the storage-lift mechanism (rotate / rise-fall / extend-shrink and spares).
//  - Each axis accepts a move command (direction, half-period, step count) over a valid/ready handshake.
//  - Emits exactly that many step pulses, then reports done.
//  - Sits between the location/sequencing controller and the motor drivers.
//  - Replaces free-running divider clocks gated by enables: pulses are counted and moves end on an exact step, with abort support.
// PARAMETERS
//  N_AXIS      3      number of independent axes
//  DIV_W       16     width of half-period field (clk cycles)
//  STEP_W      16     width of step-count field
//  RAMP_START  24000  starting half-period when ramping (RAMP_EN only)
//  RAMP_DEC    64     half-period decrement per completed step (RAMP_EN only)
// PORTS
//  clk              in   1               system clock
//  rst_n            in   1               asynchronous, active-low reset
//  cmd_valid        in   N_AXIS          per-axis command valid
//  cmd_ready        out  N_AXIS          per-axis ready (axis idle)
//  cmd_dir          in   N_AXIS          direction to latch (0 fwd/up/cw, 1 rev/down/ccw)
//  cmd_half_period  in   N_AXIS*DIV_W    target half-period per axis, axis i at [i*DIV_W +: DIV_W]
//  cmd_steps        in   N_AXIS*STEP_W   steps to issue per axis, axis i at [i*STEP_W +: STEP_W]
//  abort            in   N_AXIS          per-axis stop request
//  step_pulse       out  N_AXIS          registered step output
//  step_dir         out  N_AXIS          latched direction, stable for the whole move
//  busy             out  N_AXIS          axis executing a move
//  done             out  N_AXIS          1-cycle pulse: move completed or aborted
//  aborted          out  N_AXIS          high from an abort's done cycle until next accept
//  steps_done       out  N_AXIS*STEP_W   steps completed in current or last move
// BEHAVIOUR
//  - Reset: all outputs 0 except cmd_ready = all 1s; axes enter IDLE.
//  - Per-axis FSM: IDLE -> HIGH -> LOW -> (HIGH | IDLE). Axes are fully independent.
//  - Accept: cmd_valid[i] & cmd_ready[i] in IDLE latches dir, half-period and steps.
//    - A half-period of 0 is treated as 1.
//    - cmd_ready drops the next cycle; steps_done and aborted clear.
//  - cmd_steps == 0: no pulse is issued; done pulses the cycle after accept; axis returns to IDLE.
//  - Otherwise the axis enters HIGH: step_pulse = 1 starting the cycle after accept.
//  - HIGH and LOW phases each last exactly H cycles (H = active half-period).
//  - A step completes at the end of LOW; steps_done increments at that point.
//  - On the final step's LOW expiry: state -> IDLE; done = 1 and cmd_ready = 1 in the same cycle.
//    - A new command may be accepted in that cycle (back-to-back, no gap pulse).
//  - Period per step = 2H clk; total move = 2H*steps cycles from the first high to done.
//  - abort[i] in HIGH or LOW:
//    - step_pulse = 0 next cycle; state -> IDLE; done = 1 and aborted = 1 that cycle.
//    - steps_done holds the completed-step count; a partial step is not counted.
//  - abort in IDLE is ignored. If abort and cmd_valid are high in the same IDLE cycle, the command is accepted.
//  - cmd_valid while busy: ignored (not queued). The sequencer must hold valid until ready.
//  - Async reset mid-move: step_pulse drops immediately and all state clears.
//  - Counters saturate at their widths; the half-period counter never wraps below 1.
// CONFIGURATION
//  RAMP_EN defined:
//    - Each move starts at half-period max(RAMP_START, target).
//    - After each completed step, half-period -= RAMP_DEC, floored at target.
//    - No deceleration ramp.
//  RAMP_EN undefined:
//    - Constant target half-period for the whole move.
//    - RAMP_START / RAMP_DEC unused.
// STRUCTURE
//  - Shared package step_gen_pkg:
//    - FSM state encoding (ST_IDLE, ST_HIGH, ST_LOW).
//    - Default widths (DIV_W, STEP_W).
//    - Canonical per-machine half-periods: ROT 4800, LIFT 24000, EXT 12000.
//  - Sub-module step_axis: one FSM plus half-period, step and ramp counters.
//  - The top instantiates N_AXIS copies via generate and slices the packed buses.
// TESTING
//  1. Reset, then axis0 cmd(dir=1, H=4, steps=3) -> 3 pulses, each 4 clk high / 4 clk low; done at cycle 24 after the first high; steps_done = 3; step_dir = 1 throughout.
//  2. steps=0, H=10 -> no pulse; done 1 cycle after accept; cmd_ready back high.
//  3. Abort axis1 during the 2nd HIGH of a steps=5, H=3 move -> pulse low next cycle; done & aborted = 1; steps_done = 1.
//  4. Axes 0/1/2 started the same cycle with H = 2/3/5, steps = 4 -> independent done at cycles 16/24/40; no cross-talk.
//  5. valid held at done: cmd A (H=2, steps=2) then B queued on valid -> B accepted in A's done cycle; first high of B the next cycle; no missing/extra pulse.
//  6. RAMP_EN, RAMP_START=20, RAMP_DEC=5, target H=8, steps=5 -> half-periods 20, 15, 10, 8, 8.

Source files
------------

// File: rtl/step_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : step_gen_pkg
//  Purpose : Shared definitions for the multi-axis step generator:
//            per-axis FSM state encoding, default bus widths and the
//            canonical half-periods of the storage-lift mechanisms.
//  Ports   : none (package)
//  Revision: 1.0  initial release
// ============================================================================
package step_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam int DEF_DIV_W  = 16;
    localparam int DEF_STEP_W = 16;

    // Canonical target half-periods (clk cycles) per machine.
    localparam int HP_ROT  = 4800;
    localparam int HP_LIFT = 24000;
    localparam int HP_EXT  = 12000;

endpackage
`default_nettype wire

// File: rtl/step_axis.sv
`default_nettype none
// ============================================================================
//  Module  : step_axis
//  Purpose : One stepper axis: accepts a move command, emits exactly the
//            commanded number of step pulses (H high / H low each), reports
//            done, supports abort. Optional acceleration ramp (RAMP_EN).
//  Macro   : RAMP_EN - start at max(RAMP_START, target) half-period and
//            reduce by RAMP_DEC after each completed step, floored at target.
//  Ports   : clk, rst_n (async, active-low)
//            cmd_valid/cmd_ready handshake, cmd_dir, cmd_half_period,
//            cmd_steps, abort in; step_pulse, step_dir, busy, done,
//            aborted, steps_done out (all registered).
//  Revision: 1.0  initial release
// ============================================================================
module step_axis
    import step_gen_pkg::*;
#(
    parameter int DIV_W      = DEF_DIV_W,
    parameter int STEP_W     = DEF_STEP_W,
    parameter int RAMP_START = 24000,
    parameter int RAMP_DEC   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [DIV_W-1:0]  cmd_half_period,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              abort,
    output logic              step_pulse,
    output logic              step_dir,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [STEP_W-1:0] steps_done
);

    localparam logic [DIV_W-1:0]  ONE_D  = 1;
    localparam logic [STEP_W-1:0] ONE_S  = 1;
    localparam logic [DIV_W-1:0]  RSTART = DIV_W'(RAMP_START);
    localparam logic [DIV_W-1:0]  RDEC   = DIV_W'(RAMP_DEC);

    state_t            state;
    logic [DIV_W-1:0]  half;       // active half-period
    logic [DIV_W-1:0]  phase_cnt;  // 1..half within the current phase
    logic [STEP_W-1:0] steps_tgt;

    // A zero half-period would never expire; treat it as 1.
    logic [DIV_W-1:0] target_hp;
    logic [DIV_W-1:0] start_hp;
    logic [DIV_W-1:0] next_hp;
    logic             last_step;

    assign target_hp = (cmd_half_period == '0) ? ONE_D : cmd_half_period;
    // steps_done < steps_tgt always holds while moving, so it cannot wrap.
    assign last_step = (steps_done == steps_tgt - ONE_S);

`ifdef RAMP_EN
    logic [DIV_W-1:0] floor_hp;

    assign start_hp = (target_hp < RSTART) ? RSTART : target_hp;
    // Widened compare so target + decrement cannot overflow.
    assign next_hp  = ({1'b0, half} > ({1'b0, floor_hp} + {1'b0, RDEC}))
                    ? (half - RDEC) : floor_hp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            floor_hp <= '0;
        end else if (state == ST_IDLE && cmd_valid) begin
            floor_hp <= target_hp;
        end
    end
`else
    assign start_hp = target_hp;
    assign next_hp  = half;
    logic unused_ramp;
    assign unused_ramp = ^{RSTART, RDEC};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            half       <= '0;
            phase_cnt  <= '0;
            steps_tgt  <= '0;
            cmd_ready  <= 1'b1;
            step_pulse <= 1'b0;
            step_dir   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            steps_done <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Abort is ignored here; a command always wins.
                    if (cmd_valid) begin
                        step_dir   <= cmd_dir;
                        half       <= start_hp;
                        steps_tgt  <= cmd_steps;
                        steps_done <= '0;
                        aborted    <= 1'b0;
                        phase_cnt  <= ONE_D;
                        if (cmd_steps == '0) begin
                            done <= 1'b1;
                        end else begin
                            state      <= ST_HIGH;
                            step_pulse <= 1'b1;
                            cmd_ready  <= 1'b0;
                            busy       <= 1'b1;
                        end
                    end
                end
                ST_HIGH, ST_LOW: begin
                    if (abort) begin
                        state      <= ST_IDLE;
                        step_pulse <= 1'b0;
                        cmd_ready  <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        aborted    <= 1'b1;
                    end else if (phase_cnt != half) begin
                        phase_cnt <= phase_cnt + ONE_D;
                    end else if (state == ST_HIGH) begin
                        state      <= ST_LOW;
                        step_pulse <= 1'b0;
                        phase_cnt  <= ONE_D;
                    end else begin
                        // End of LOW: one full step completed.
                        steps_done <= steps_done + ONE_S;
                        phase_cnt  <= ONE_D;
                        if (last_step) begin
                            state     <= ST_IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state      <= ST_HIGH;
                            step_pulse <= 1'b1;
                            half       <= next_hp;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    step_pulse <= 1'b0;
                    cmd_ready  <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_axis_step_gen.sv
`default_nettype none
// ============================================================================
//  Module  : multi_axis_step_gen
//  Purpose : N independent stepper pulse generators (rotate / lift /
//            extend and spares) between the sequencing controller and
//            the motor drivers. Each axis is one step_axis instance.
//  Macro   : RAMP_EN - enables the per-move acceleration ramp.
//  Ports   : clk, rst_n (async, active-low)
//            per-axis vectors: cmd_valid, cmd_ready, cmd_dir, abort,
//            step_pulse, step_dir, busy, done, aborted
//            packed buses: cmd_half_period (DIV_W/axis),
//            cmd_steps, steps_done (STEP_W/axis); axis i at [i*W +: W]
//  Revision: 1.0  initial release
// ============================================================================
module multi_axis_step_gen
    import step_gen_pkg::*;
#(
    parameter int N_AXIS     = 3,
    parameter int DIV_W      = DEF_DIV_W,
    parameter int STEP_W     = DEF_STEP_W,
    parameter int RAMP_START = 24000,
    parameter int RAMP_DEC   = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_AXIS-1:0]        cmd_valid,
    output logic [N_AXIS-1:0]        cmd_ready,
    input  logic [N_AXIS-1:0]        cmd_dir,
    input  logic [N_AXIS*DIV_W-1:0]  cmd_half_period,
    input  logic [N_AXIS*STEP_W-1:0] cmd_steps,
    input  logic [N_AXIS-1:0]        abort,
    output logic [N_AXIS-1:0]        step_pulse,
    output logic [N_AXIS-1:0]        step_dir,
    output logic [N_AXIS-1:0]        busy,
    output logic [N_AXIS-1:0]        done,
    output logic [N_AXIS-1:0]        aborted,
    output logic [N_AXIS*STEP_W-1:0] steps_done
);

    for (genvar i = 0; i < N_AXIS; i++) begin : g_axis
        step_axis #(
            .DIV_W      (DIV_W),
            .STEP_W     (STEP_W),
            .RAMP_START (RAMP_START),
            .RAMP_DEC   (RAMP_DEC)
        ) u_axis (
            .clk             (clk),
            .rst_n           (rst_n),
            .cmd_valid       (cmd_valid[i]),
            .cmd_ready       (cmd_ready[i]),
            .cmd_dir         (cmd_dir[i]),
            .cmd_half_period (cmd_half_period[i*DIV_W +: DIV_W]),
            .cmd_steps       (cmd_steps[i*STEP_W +: STEP_W]),
            .abort           (abort[i]),
            .step_pulse      (step_pulse[i]),
            .step_dir        (step_dir[i]),
            .busy            (busy[i]),
            .done            (done[i]),
            .aborted         (aborted[i]),
            .steps_done      (steps_done[i*STEP_W +: STEP_W])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_axis_step_gen.sv
`default_nettype none
// ============================================================================
//  Module  : tb_multi_axis_step_gen
//  Purpose : Self-checking bench for multi_axis_step_gen: table of single
//            moves plus hand-written abort, concurrent, back-to-back,
//            async-reset and (RAMP_EN) ramp sequences.
//  Revision: 1.0  initial release
// ============================================================================
module tb_multi_axis_step_gen;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int SW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    cmd_valid = '0;
    logic [N-1:0]    cmd_ready;
    logic [N-1:0]    cmd_dir = '0;
    logic [N*DW-1:0] cmd_half_period = '0;
    logic [N*SW-1:0] cmd_steps = '0;
    logic [N-1:0]    abort = '0;
    logic [N-1:0]    step_pulse;
    logic [N-1:0]    step_dir;
    logic [N-1:0]    busy;
    logic [N-1:0]    done;
    logic [N-1:0]    aborted;
    logic [N*SW-1:0] steps_done;

    always #5 clk = ~clk;

    multi_axis_step_gen #(
        .N_AXIS(N), .DIV_W(DW), .STEP_W(SW), .RAMP_START(20), .RAMP_DEC(5)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_half_period(cmd_half_period), .cmd_steps(cmd_steps),
        .abort(abort), .step_pulse(step_pulse), .step_dir(step_dir),
        .busy(busy), .done(done), .aborted(aborted), .steps_done(steps_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_cmd(input int a, input bit dir, input int hp, input int steps);
        cmd_dir[a]                  = dir;
        cmd_half_period[a*DW +: DW] = DW'(hp);
        cmd_steps[a*SW +: SW]       = SW'(steps);
    endtask

    function automatic int sd(input int a);
        return int'(steps_done[a*SW +: SW]);
    endfunction

    // Per-axis observations collected by monitor(); k = 0 is the first
    // negedge after the accepting edge.
    int mon_done[N], mon_pulses[N], mon_runs[N][8], mon_nruns[N];
    int mon_dirbad[N], mon_rdy[N], mon_busy[N], mon_sd[N];

    task automatic monitor(input logic [N-1:0] mask, input logic [N-1:0] edir, input int budget);
        int  cur[N];
        bit  prev[N];
        for (int a = 0; a < N; a++) begin
            mon_done[a] = -1; mon_pulses[a] = 0; mon_nruns[a] = 0;
            mon_dirbad[a] = 0; mon_rdy[a] = -1; mon_busy[a] = -1; mon_sd[a] = -1;
            cur[a] = 0; prev[a] = 1'b0;
        end
        for (int k = 0; k < budget; k++) begin
            logic [N-1:0] dmask;
            @(negedge clk);
            if (k == 0) cmd_valid = '0;
            dmask = '0;
            for (int a = 0; a < N; a++) begin
                if (mask[a] && mon_done[a] < 0) begin
                    if (step_pulse[a]) begin
                        if (!prev[a]) mon_pulses[a]++;
                        cur[a]++;
                    end else if (cur[a] > 0) begin
                        if (mon_nruns[a] < 8) mon_runs[a][mon_nruns[a]] = cur[a];
                        mon_nruns[a]++;
                        cur[a] = 0;
                    end
                    prev[a] = step_pulse[a];
                    if (busy[a] && step_dir[a] !== edir[a]) mon_dirbad[a]++;
                    if (done[a]) begin
                        mon_done[a] = k;
                        mon_rdy[a]  = int'(cmd_ready[a]);
                        mon_busy[a] = int'(busy[a]);
                        mon_sd[a]   = sd(a);
                    end
                end
                if (mon_done[a] >= 0) dmask[a] = 1'b1;
            end
            if ((mask & ~dmask) == '0) break;
        end
    endtask

    typedef struct {
        int axis;
        bit dir;
        int hp;
        int steps;
        int exp_done;
        int exp_pulses;
        int exp_hi;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{0, 1'b1, 4, 3, 24, 3, 4};   // basic 3-step move
        tbl[1] = '{2, 1'b0, 10, 0, 0, 0, 0};   // zero steps: immediate done
        tbl[2] = '{1, 1'b0, 0, 2, 4, 2, 1};    // half-period 0 acts as 1
        tbl[3] = '{2, 1'b1, 1, 3, 6, 3, 1};
        tbl[4] = '{1, 1'b1, 7, 1, 14, 1, 7};

        repeat (2) @(negedge clk);
        check("reset_ready", int'(cmd_ready), 7);
        check("reset_pulse", int'(step_pulse), 0);
        check("reset_busy", int'(busy | done | aborted | step_dir), 0);
        check("reset_steps_done", int'(steps_done != '0), 0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef RAMP_EN
        // Ramp: 20, 15, 10, then floored at target 8.
        set_cmd(0, 1'b0, 8, 5);
        cmd_valid[0] = 1'b1;
        monitor(3'b001, 3'b000, 400);
        check("ramp_done_k", mon_done[0], 122);
        check("ramp_nruns", mon_nruns[0], 5);
        check("ramp_run0", mon_runs[0][0], 20);
        check("ramp_run1", mon_runs[0][1], 15);
        check("ramp_run2", mon_runs[0][2], 10);
        check("ramp_run3", mon_runs[0][3], 8);
        check("ramp_run4", mon_runs[0][4], 8);
        check("ramp_steps_done", mon_sd[0], 5);
`else
        for (int t = 0; t < 5; t++) begin
            int a;
            a = tbl[t].axis;
            set_cmd(a, tbl[t].dir, tbl[t].hp, tbl[t].steps);
            cmd_valid[a] = 1'b1;
            monitor(N'(1) << a, N'(tbl[t].dir) << a, 400);
            check($sformatf("v%0d_done_k", t), mon_done[a], tbl[t].exp_done);
            check($sformatf("v%0d_pulses", t), mon_pulses[a], tbl[t].exp_pulses);
            check($sformatf("v%0d_steps_done", t), mon_sd[a], tbl[t].steps);
            check($sformatf("v%0d_ready_at_done", t), mon_rdy[a], 1);
            check($sformatf("v%0d_busy_at_done", t), mon_busy[a], 0);
            check($sformatf("v%0d_dir", t), mon_dirbad[a], 0);
            if (tbl[t].exp_hi > 0)
                check($sformatf("v%0d_high_len", t), mon_runs[a][0], tbl[t].exp_hi);
            repeat (2) @(negedge clk);
        end

        // Abort axis1 in the second HIGH of a 5-step, H=3 move.
        set_cmd(1, 1'b0, 3, 5);
        cmd_valid[1] = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k == 0) cmd_valid = '0;
            if (k == 7) begin
                check("abort_in_high", int'(step_pulse[1]), 1);
                abort[1] = 1'b1;
            end
        end
        abort[1] = 1'b0;
        check("abort_pulse", int'(step_pulse[1]), 0);
        check("abort_done", int'(done[1]), 1);
        check("abort_aborted", int'(aborted[1]), 1);
        check("abort_steps_done", sd(1), 1);
        check("abort_ready", int'(cmd_ready[1]), 1);
        @(negedge clk);
        check("abort_done_one_cycle", int'(done[1]), 0);
        check("abort_flag_held", int'(aborted[1]), 1);
        // Abort with valid in IDLE: command accepted, aborted cleared.
        set_cmd(1, 1'b1, 1, 2);
        cmd_valid[1] = 1'b1;
        abort[1] = 1'b1;
        @(negedge clk);
        cmd_valid[1] = 1'b0;
        abort[1] = 1'b0;
        check("idle_abort_accept_busy", int'(busy[1]), 1);
        check("idle_abort_flag_clear", int'(aborted[1]), 0);
        check("idle_abort_steps_clear", sd(1), 0);
        repeat (6) @(negedge clk);
        check("idle_abort_move_done", sd(1), 2);

        // Three axes started together.
        set_cmd(0, 1'b0, 2, 4);
        set_cmd(1, 1'b1, 3, 4);
        set_cmd(2, 1'b0, 5, 4);
        cmd_valid = 3'b111;
        monitor(3'b111, 3'b010, 200);
        check("conc_done0", mon_done[0], 16);
        check("conc_done1", mon_done[1], 24);
        check("conc_done2", mon_done[2], 40);
        check("conc_hi0", mon_runs[0][3], 2);
        check("conc_hi1", mon_runs[1][3], 3);
        check("conc_hi2", mon_runs[2][3], 5);
        check("conc_pulses", mon_pulses[0] + mon_pulses[1] + mon_pulses[2], 12);
        check("conc_dir", mon_dirbad[0] + mon_dirbad[1] + mon_dirbad[2], 0);
        @(negedge clk);

        // Back-to-back: A (H=2,2 steps) then B (H=3,1 step, dir 1) on held valid.
        begin
            int ndone, d0, d1, pulses, cur, nruns;
            int runs[4];
            bit prev;
            ndone = 0; d0 = -1; d1 = -1; pulses = 0; cur = 0; nruns = 0; prev = 1'b0;
            set_cmd(0, 1'b0, 2, 2);
            cmd_valid[0] = 1'b1;
            for (int k = 0; k < 40 && ndone < 2; k++) begin
                @(negedge clk);
                if (k == 0) set_cmd(0, 1'b1, 3, 1);
                if (ndone == 1 && k == d0 + 1) begin
                    cmd_valid[0] = 1'b0;
                    check("b2b_first_high", int'(step_pulse[0]), 1);
                    check("b2b_dir_b", int'(step_dir[0]), 1);
                end
                if (step_pulse[0]) begin
                    if (!prev) pulses++;
                    cur++;
                end else if (cur > 0) begin
                    if (nruns < 4) runs[nruns] = cur;
                    nruns++;
                    cur = 0;
                end
                prev = step_pulse[0];
                if (done[0]) begin
                    if (ndone == 0) begin
                        d0 = k;
                        check("b2b_ready_at_done", int'(cmd_ready[0]), 1);
                    end else begin
                        d1 = k;
                    end
                    ndone++;
                end
            end
            cmd_valid[0] = 1'b0;
            check("b2b_done_a", d0, 8);
            check("b2b_done_b", d1, 15);
            check("b2b_pulses", pulses, 3);
            check("b2b_nruns", nruns, 3);
            if (nruns == 3) check("b2b_run_b", runs[2], 3);
            check("b2b_steps_done", sd(0), 1);
        end

        // Asynchronous reset mid-move.
        @(negedge clk);
        set_cmd(2, 1'b1, 5, 4);
        cmd_valid[2] = 1'b1;
        @(negedge clk);
        cmd_valid[2] = 1'b0;
        repeat (2) @(negedge clk);
        check("arst_pre_pulse", int'(step_pulse[2]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pulse", int'(step_pulse), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_ready", int'(cmd_ready), 7);
        check("arst_dir", int'(step_dir), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
